// File: rtl/fib_seq_gen.sv
// Streaming Fibonacci-style sequence generator: F0=a, F1=b, Fk=F(k-1)+F(k-2) up to index n,
// one term per valid/ready transfer, with last/done markers and a sticky overflow flag.
module fib_seq_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [N_W-1:0]   n,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] nxt;
  logic             nxt_carry;
  logic [N_W-1:0]   idx;
  logic [N_W-1:0]   n_q;
  logic             xfer_c;
  logic             at_last_c;
  logic [SUM_W-1:0] sum_c;

  assign xfer_c    = out_valid && out_ready;
  assign at_last_c = (idx == n_q);
  assign sum_c     = SUM_W'(out) + SUM_W'(nxt);
  assign out_last  = out_valid && at_last_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (xfer_c && at_last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; the carry rides with nxt so only presented terms flag overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      nxt       <= '0;
      nxt_carry <= 1'b0;
      idx       <= '0;
      n_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q       <= n;
            out       <= a;
            nxt       <= b;
            nxt_carry <= 1'b0;
            idx       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (xfer_c) begin
            if (at_last_c) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out       <= nxt;
              nxt       <= sum_c[WIDTH-1:0];
              nxt_carry <= sum_c[WIDTH];
              overflow  <= overflow | nxt_carry;
              idx       <= idx + N_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: 32-bit and 8-bit instances share stimulus and are
// compared every cycle against a plain-arithmetic Fibonacci reference.
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  n;
  logic        out_ready;

  logic [31:0] o32;
  logic        v32, l32, busy32, done32, ov32;
  logic [7:0]  o8;
  logic        v8, l8, busy8, done8, ov8;

  int checks = 0;
  int errors = 0;

  // Reference terms and cumulative overflow per index, for both widths
  logic [31:0] e32 [256];
  logic [7:0]  e8  [256];
  bit          f32 [256];
  bit          f8  [256];

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(32), .N_W(8)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .n(n),
    .out(o32), .out_valid(v32), .out_ready(out_ready), .out_last(l32),
    .busy(busy32), .done(done32), .overflow(ov32)
  );

  fib_seq_gen #(.WIDTH(8), .N_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]), .n(n),
    .out(o8), .out_valid(v8), .out_ready(out_ready), .out_last(l8),
    .busy(busy8), .done(done8), .overflow(ov8)
  );

  function automatic void build(input logic [31:0] sa, input logic [31:0] sb, input int nn);
    longint unsigned s;
    e32[0] = sa; e32[1] = sb; e8[0] = sa[7:0]; e8[1] = sb[7:0];
    f32[0] = 1'b0; f32[1] = 1'b0; f8[0] = 1'b0; f8[1] = 1'b0;
    for (int k = 2; k <= nn; k++) begin
      s = longint'(e32[k-1]) + longint'(e32[k-2]);
      e32[k] = 32'(s % 64'h1_0000_0000);
      f32[k] = f32[k-1] | (s >= 64'h1_0000_0000);
      s = longint'(e8[k-1]) + longint'(e8[k-2]);
      e8[k] = 8'(s % 256);
      f8[k] = f8[k-1] | (s >= 256);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_term(input int k, input int nn);
    chk("out32",   64'(o32),    64'(e32[k]));
    chk("valid32", 64'(v32),    64'd1);
    chk("last32",  64'(l32),    64'(k == nn));
    chk("busy32",  64'(busy32), 64'd1);
    chk("done32",  64'(done32), 64'd0);
    chk("ovf32",   64'(ov32),   64'(f32[k]));
    chk("out8",    64'(o8),     64'(e8[k]));
    chk("valid8",  64'(v8),     64'd1);
    chk("last8",   64'(l8),     64'(k == nn));
    chk("busy8",   64'(busy8),  64'd1);
    chk("done8",   64'(done8),  64'd0);
    chk("ovf8",    64'(ov8),    64'(f8[k]));
  endtask

  // After the final transfer: DONE cycle (done=1) then IDLE; last term and flag held
  task automatic chk_end(input int nn, input bit exp_done);
    chk("end_out32",   64'(o32),    64'(e32[nn]));
    chk("end_valid32", 64'(v32),    64'd0);
    chk("end_last32",  64'(l32),    64'd0);
    chk("end_busy32",  64'(busy32), 64'd0);
    chk("end_done32",  64'(done32), 64'(exp_done));
    chk("end_ovf32",   64'(ov32),   64'(f32[nn]));
    chk("end_out8",    64'(o8),     64'(e8[nn]));
    chk("end_valid8",  64'(v8),     64'd0);
    chk("end_last8",   64'(l8),     64'd0);
    chk("end_busy8",   64'(busy8),  64'd0);
    chk("end_done8",   64'(done8),  64'(exp_done));
    chk("end_ovf8",    64'(ov8),    64'(f8[nn]));
  endtask

  task automatic chk_zero();
    chk("rst_out32",  64'(o32), 64'd0);
    chk("rst_ctl32",  64'({v32, l32, busy32, done32, ov32}), 64'd0);
    chk("rst_out8",   64'(o8),  64'd0);
    chk("rst_ctl8",   64'({v8, l8, busy8, done8, ov8}), 64'd0);
  endtask

  // mode: 0 ready=1 quiet, 1 random ready, 2 toggling pattern, 3 ready=1 with junk starts.
  // abort_at >= 0 pulses reset right after that term index has been checked.
  task automatic run(input logic [31:0] sa, input logic [31:0] sb, input int nn,
                     input int mode, input int abort_at);
    bit pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    int k = 0;
    int cyc = 0;
    bit fin = 1'b0;
    build(sa, sb, nn);
    start = 1'b1; a = sa; b = sb; n = 8'(nn); out_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      chk_term(k, nn);
      if (k == abort_at) begin
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_zero();
        rst_n = 1'b1;
        return;
      end
      case (mode)
        1:       out_ready = (cyc > 500) ? 1'b1 : 1'($urandom_range(0, 1));
        2:       out_ready = pat[cyc % 12];
        default: out_ready = 1'b1;
      endcase
      cyc++;
      start = (mode != 0) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      a = $urandom; b = $urandom; n = 8'($urandom);
      if (out_ready) begin
        if (k == nn) fin = 1'b1;
        else         k++;
      end
    end
    @(negedge clk);
    chk_end(nn, 1'b1);
    start = (mode != 0) ? 1'b1 : 1'b0;
    @(negedge clk);
    chk_end(nn, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; n = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero();

    run(32'd2, 32'd2, 6, 0, -1);
    run(32'd1, 32'd1, 13, 0, -1);
    run(32'd1, 32'd1, 12, 0, -1);
    run(32'd0, 32'd1, 5, 2, -1);
    run(32'd7, 32'd9, 0, 0, -1);
    run(32'd7, 32'd9, 1, 0, -1);
    run(32'd5, 32'd8, 10, 3, -1);
    run(32'd200, 32'd100, 10, 0, 2);
    run(32'd3, 32'd4, 5, 0, -1);
    run(32'hFFFF_FFF0, 32'h20, 20, 1, -1);
    run(32'd1, 32'd2, 255, 0, -1);
    for (int i = 0; i < 12; i++)
      run($urandom, $urandom, int'($urandom_range(0, 40)), 1 + (i % 3), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
